// File: rtl/ddp_pkg.sv
// ddp_pkg: shared widths and destination encodings for the dual-destination packet router.
package ddp_pkg;
    localparam int PACKET_W = 38;
    localparam int DEST_BIT = 37;
    localparam int CNT_W    = 16;
    localparam logic DEST_EX = 1'b1;
    localparam logic DEST_IN = 1'b0;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/branch_slot.sv
// branch_slot: one two-phase output channel holding its phase, packet register and delivery counter.
module branch_slot
    import ddp_pkg::*;
#(
    parameter int W = PACKET_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         ack_in,
    input  logic [W-1:0] packet_in,
    output logic         accept,
    output logic         send_out,
    output logic [W-1:0] packet_out,
    output cnt_t         cnt
);
    logic busy;
    // A spurious ack toggle makes the phases disagree, so the slot then looks busy until reset.
    assign busy   = send_out ^ ack_in;
    assign accept = req & ~busy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_out   <= 1'b0;
            packet_out <= '0;
            cnt        <= '0;
        end else if (accept) begin
            send_out   <= ~send_out;
            packet_out <= packet_in;
            cnt        <= cnt + cnt_t'(1);
        end
    end
endmodule

// File: rtl/branch_stage.sv
// branch_stage: routes each upstream two-phase packet to the EX or IN output selected by one packet bit.
module branch_stage
    import ddp_pkg::*;
#(
    parameter int PACKET_W = ddp_pkg::PACKET_W,
    parameter int DEST_BIT = ddp_pkg::DEST_BIT
) (
    input  logic                CLK,
    input  logic                MR,
    input  logic                Send_in,
    input  logic [PACKET_W-1:0] PACKET_IN,
    output logic                Ack_out,
    output logic                Send_out_EX,
    output logic                Send_out_IN,
    input  logic                Ack_in_EX,
    input  logic                Ack_in_IN,
    output logic [PACKET_W-1:0] PACKET_OUT_EX,
    output logic [PACKET_W-1:0] PACKET_OUT_IN,
    output cnt_t                CNT_EX,
    output cnt_t                CNT_IN
);
    logic pending, target, accept_ex, accept_in;
    assign pending = Send_in ^ Ack_out;
    assign target  = PACKET_IN[DEST_BIT];
    branch_slot #(.W(PACKET_W)) u_ex (
        .clk(CLK), .rst(MR), .req(pending && target == DEST_EX), .ack_in(Ack_in_EX),
        .packet_in(PACKET_IN), .accept(accept_ex), .send_out(Send_out_EX),
        .packet_out(PACKET_OUT_EX), .cnt(CNT_EX)
    );
    branch_slot #(.W(PACKET_W)) u_in (
        .clk(CLK), .rst(MR), .req(pending && target == DEST_IN), .ack_in(Ack_in_IN),
        .packet_in(PACKET_IN), .accept(accept_in), .send_out(Send_out_IN),
        .packet_out(PACKET_OUT_IN), .cnt(CNT_IN)
    );
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) Ack_out <= 1'b0;
        else if (accept_ex || accept_in) Ack_out <= ~Ack_out;
    end
endmodule

// File: tb/tb_branch_stage.sv
// tb_branch_stage: directed vector table plus hand sequences for stalls, blocking, reset and counter wrap.
module tb_branch_stage;
    import ddp_pkg::*;
    logic                CLK = 1'b0;
    logic                MR, Send_in, Ack_in_EX, Ack_in_IN;
    logic [PACKET_W-1:0] PACKET_IN;
    logic                Ack_out, Send_out_EX, Send_out_IN;
    logic [PACKET_W-1:0] PACKET_OUT_EX, PACKET_OUT_IN;
    cnt_t                CNT_EX, CNT_IN;
    int tests = 0, fails = 0;

    branch_stage dut (
        .CLK(CLK), .MR(MR), .Send_in(Send_in), .PACKET_IN(PACKET_IN), .Ack_out(Ack_out),
        .Send_out_EX(Send_out_EX), .Send_out_IN(Send_out_IN), .Ack_in_EX(Ack_in_EX),
        .Ack_in_IN(Ack_in_IN), .PACKET_OUT_EX(PACKET_OUT_EX), .PACKET_OUT_IN(PACKET_OUT_IN),
        .CNT_EX(CNT_EX), .CNT_IN(CNT_IN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic snd; logic [37:0] pkt; logic aex; logic ain;
        logic ack; logic sox; logic soi; logic [37:0] pex; logic [37:0] pin; logic [15:0] cex; logic [15:0] cin;
    } vec_t;

    localparam logic [37:0] P1 = 38'h20_0000_0001, PA = 38'h00_0000_00AB;
    localparam logic [37:0] P2 = 38'h20_0000_0002, P3 = 38'h20_0000_0003;

    function automatic logic [110:0] outs();
        return {Ack_out, Send_out_EX, Send_out_IN, PACKET_OUT_EX, PACKET_OUT_IN, CNT_EX, CNT_IN};
    endfunction

    task automatic chk(input string name, input logic [110:0] act, input logic [110:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        MR = 1'b1; Send_in = 1'b0; Ack_in_EX = 1'b0; Ack_in_IN = 1'b0; PACKET_IN = '0;
        #1;
        chk("reset_zero", outs(), '0);
        @(negedge CLK);
        MR = 1'b0;
    endtask

    task automatic send(input logic [37:0] p);
        PACKET_IN = p;
        Send_in = ~Send_in;
    endtask

    vec_t v[7];

    initial begin
        v[0] = '{1'b0, 38'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 38'h0, 38'h0, 16'd0, 16'd0};
        v[1] = '{1'b1, P1,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P1,    38'h0, 16'd1, 16'd0};
        v[2] = '{1'b1, PA,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, P1,    PA,    16'd1, 16'd1};
        v[3] = '{1'b1, P2,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, P2,    PA,    16'd2, 16'd1};
        v[4] = '{1'b1, P3,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, P2,    PA,    16'd2, 16'd1};
        v[5] = '{1'b0, P3,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, P3,    PA,    16'd3, 16'd1};
        v[6] = '{1'b0, P3,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, P3,    PA,    16'd3, 16'd1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            PACKET_IN = v[i].pkt;
            if (v[i].snd) Send_in = ~Send_in;
            if (v[i].aex) Ack_in_EX = ~Ack_in_EX;
            if (v[i].ain) Ack_in_IN = ~Ack_in_IN;
            step();
            chk($sformatf("vec%0d", i), outs(),
                {v[i].ack, v[i].sox, v[i].soi, v[i].pex, v[i].pin, v[i].cex, v[i].cin});
        end

        do_reset();
        send(P1); step();
        send(P2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold", {Ack_out, PACKET_OUT_EX}, {1'b1, P1});
        end
        Ack_in_EX = ~Ack_in_EX; step();
        chk("stall_release", {Ack_out, Send_out_EX, PACKET_OUT_EX, CNT_EX}, {1'b0, 1'b0, P2, 16'd2});

        do_reset();
        send(P1); step();
        send(P2);
        step(); step();
        chk("hol_stall", {Ack_out, Send_out_IN}, 2'b10);
        Ack_in_EX = ~Ack_in_EX; step();
        chk("hol_ex_accept", {Ack_out, PACKET_OUT_EX, Send_out_IN}, {1'b0, P2, 1'b0});
        send(PA); step();
        chk("hol_in_after", {Ack_out, Send_out_IN, PACKET_OUT_IN, CNT_IN}, {1'b1, 1'b1, PA, 16'd1});

        do_reset();
        Ack_in_IN = 1'b1;
        send(PA); step(); step();
        chk("spurious_ack_blocks", {Ack_out, Send_out_IN, CNT_IN}, 18'd0);

        do_reset();
        send(P1); step();
        send(PA); step();
        chk("both_busy", {Ack_out, Send_out_EX, Send_out_IN}, 3'b011);
        #2;
        do_reset();
        send(P3); step();
        chk("post_reset_route", outs(), {1'b1, 1'b1, 1'b0, P3, 38'h0, 16'd1, 16'd0});

        do_reset();
        begin
            int errs = 0;
            logic [37:0] exp_p;
            for (int i = 0; i < 65537; i++) begin
                exp_p = {1'b1, 37'(i)};
                send(exp_p); step();
                if (Send_out_EX !== ~Ack_in_EX || PACKET_OUT_EX !== exp_p || Ack_out !== Send_in) errs++;
                Ack_in_EX = Send_out_EX;
            end
            chk("wrap_order_errs", 111'(errs), '0);
            chk("wrap_cnt", {CNT_EX, CNT_IN}, {16'd1, 16'd0});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
